// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, requester
// indices and the external SRAM bus geometry.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int PORT_VID = 0;
  localparam int PORT_CPU = 1;
  localparam int PORT_DMA = 2;

  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 8;

endpackage

// File: rtl/sram_arb_prio.sv
// Fixed-priority selector (vid > cpu > dma) with a DMA anti-starvation counter
// that lifts DMA above the CPU once it has lost DMA_MAX_WAIT arbitrations.
module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [2:0] elig,
  input  logic       dma_req,
  output logic [2:0] grant,
  output logic       grant_vld
);

  localparam int WAIT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);

  logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
  logic              dma_boost;

  assign dma_boost = (dma_wait_q == WAIT_MAX);

  always_comb begin
    grant = '0;
    if (elig[PORT_VID])                  grant[PORT_VID] = 1'b1;
    else if (dma_boost && elig[PORT_DMA]) grant[PORT_DMA] = 1'b1;
    else if (elig[PORT_CPU])             grant[PORT_CPU] = 1'b1;
    else if (elig[PORT_DMA])             grant[PORT_DMA] = 1'b1;
    if (!arb_en) grant = '0;
    grant_vld = |grant;
  end

  // Only IDLE edges count as arbitrations; a dropped request forgets its history.
  always_comb begin
    dma_wait_d = dma_wait_q;
    if (!dma_req) begin
      dma_wait_d = '0;
    end else if (arb_en) begin
      if (grant[PORT_DMA])
        dma_wait_d = '0;
      else if (elig[PORT_DMA] && !dma_boost)
        dma_wait_d = dma_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dma_wait_q <= '0;
    else        dma_wait_q <= dma_wait_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between video, CPU and DMA requesters and
// sequences the read / setup-write-hold timing on the SRAM pins.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int WR_PULSE      = 1,
  parameter int DMA_MAX_WAIT  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vidReq,
  input  logic [SRAM_ADDR_W-1:0] vidAddr,
  output logic                   vidAck,
  output logic [SRAM_DATA_W-1:0] vidData,
  input  logic                   cpuReq,
  input  logic                   cpuWr,
  input  logic [SRAM_ADDR_W-1:0] cpuAddr,
  input  logic [SRAM_DATA_W-1:0] cpuDi,
  output logic                   cpuAck,
  output logic [SRAM_DATA_W-1:0] cpuDo,
  input  logic                   dmaReq,
  input  logic                   dmaWr,
  input  logic [SRAM_ADDR_W-1:0] dmaAddr,
  input  logic [SRAM_DATA_W-1:0] dmaDi,
  output logic                   dmaAck,
  output logic [SRAM_DATA_W-1:0] dmaDo,
  output logic                   sramWr,
  inout  wire  [SRAM_DATA_W-1:0] sramData,
  output logic [SRAM_ADDR_W-1:0] sramAddr,
  output logic                   busy
);

  localparam logic [7:0] RD_LAST = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]             who_q, who_d;
  logic [2:0]             ack_q, ack_d;
  logic [SRAM_DATA_W-1:0] vid_data_q, vid_data_d;
  logic [SRAM_DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [SRAM_DATA_W-1:0] dma_data_q, dma_data_d;

  logic [2:0]             elig;
  logic [2:0]             grant;
  logic                   grant_vld;
  logic                   arb_en;
  logic                   rd_last;
  logic                   wr_n;
  logic                   bus_oe;
  logic [SRAM_ADDR_W-1:0] sel_addr;
  logic [SRAM_DATA_W-1:0] sel_di;
  logic                   sel_wr;

  // A request seen during its own ack cycle is the tail of the finished access.
  assign elig   = {dmaReq & ~ack_q[PORT_DMA],
                   cpuReq & ~ack_q[PORT_CPU],
                   vidReq & ~ack_q[PORT_VID]};
  assign arb_en = (state_q == ST_IDLE);

  sram_arb_prio #(
    .DMA_MAX_WAIT(DMA_MAX_WAIT)
  ) u_prio (
    .clk      (clock),
    .rst_n    (reset),
    .arb_en   (arb_en),
    .elig     (elig),
    .dma_req  (dmaReq),
    .grant    (grant),
    .grant_vld(grant_vld)
  );

  always_comb begin
    sel_addr = vidAddr;
    sel_di   = '0;
    sel_wr   = 1'b0;
    if (grant[PORT_CPU]) begin
      sel_addr = cpuAddr;
      sel_di   = cpuDi;
      sel_wr   = cpuWr;
    end else if (grant[PORT_DMA]) begin
      sel_addr = dmaAddr;
      sel_di   = dmaDi;
      sel_wr   = dmaWr;
    end
  end

  assign rd_last = (state_q == ST_READ) && (cnt_q == RD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = sel_wr ? ST_SETUP : ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (rd_last) state_d = ST_IDLE;
        else         cnt_d   = cnt_q + 1'b1;
      end
      ST_SETUP: begin
        state_d = ST_WRITE;
        cnt_d   = '0;
      end
      ST_WRITE: begin
        if (cnt_q == WR_LAST) state_d = ST_HOLD;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    who_d      = who_q;
    vid_data_d = vid_data_q;
    cpu_data_d = cpu_data_q;
    dma_data_d = dma_data_q;
    ack_d      = '0;
    if (arb_en && grant_vld) begin
      addr_d  = sel_addr;
      wdata_d = sel_di;
      who_d   = grant;
    end
    if (rd_last) begin
      ack_d = who_q;
      if (who_q[PORT_VID]) vid_data_d = sramData;
      if (who_q[PORT_CPU]) cpu_data_d = sramData;
      if (who_q[PORT_DMA]) dma_data_d = sramData;
    end
    if (state_q == ST_HOLD) ack_d = who_q;
  end

  always_comb begin
    wr_n   = 1'b1;
    bus_oe = 1'b0;
    case (state_q)
      ST_SETUP, ST_HOLD: bus_oe = 1'b1;
      ST_WRITE: begin
        bus_oe = 1'b1;
        wr_n   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      who_q      <= '0;
      ack_q      <= '0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
      dma_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      who_q      <= who_d;
      ack_q      <= ack_d;
      vid_data_q <= vid_data_d;
      cpu_data_q <= cpu_data_d;
      dma_data_q <= dma_data_d;
    end
  end

  // Write data only reaches the pins through bus_oe, which reset clears.
  always_ff @(posedge clock) begin
    wdata_q <= wdata_d;
  end

  assign sramAddr = addr_q;
  assign sramWr   = wr_n;
  assign sramData = bus_oe ? wdata_q : 'z;
  assign busy     = (state_q != ST_IDLE);
  assign vidAck   = ack_q[PORT_VID];
  assign cpuAck   = ack_q[PORT_CPU];
  assign dmaAck   = ack_q[PORT_DMA];
  assign vidData  = vid_data_q;
  assign cpuDo    = cpu_data_q;
  assign dmaDo    = dma_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single accesses plus
// hand-written sequences for contention, starvation and reset corners.
module tb_sram_arbiter;

  localparam int TB_WR_PULSE = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vidReq = 1'b0, cpuReq = 1'b0, cpuWr = 1'b0, dmaReq = 1'b0, dmaWr = 1'b0;
  logic [18:0] vidAddr = '0, cpuAddr = '0, dmaAddr = '0;
  logic [7:0]  cpuDi = '0, dmaDi = '0;
  logic        vidAck, cpuAck, dmaAck, sramWr, busy;
  logic [7:0]  vidData, cpuDo, dmaDo;
  logic [18:0] sramAddr;
  wire  [7:0]  sram_bus;

  sram_arbiter #(.ACCESS_CYCLES(2), .WR_PULSE(TB_WR_PULSE), .DMA_MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset),
    .vidReq(vidReq), .vidAddr(vidAddr), .vidAck(vidAck), .vidData(vidData),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuDi(cpuDi),
    .cpuAck(cpuAck), .cpuDo(cpuDo),
    .dmaReq(dmaReq), .dmaWr(dmaWr), .dmaAddr(dmaAddr), .dmaDi(dmaDi),
    .dmaAck(dmaAck), .dmaDo(dmaDo),
    .sramWr(sramWr), .sramData(sram_bus), .sramAddr(sramAddr), .busy(busy)
  );

  always #7 clock = ~clock;

  // SRAM model: up to three known locations answer reads, anything else reads 0xEE.
  logic        mem_oe = 1'b0;
  logic [18:0] rd_addr_a = '0, rd_addr_b = '0, rd_addr_c = '0;
  logic [7:0]  rd_dat_a = '0, rd_dat_b = '0, rd_dat_c = '0;
  logic [7:0]  mem_rd;
  always_comb begin
    mem_rd = 8'hEE;
    if (sramAddr == rd_addr_a)      mem_rd = rd_dat_a;
    else if (sramAddr == rd_addr_b) mem_rd = rd_dat_b;
    else if (sramAddr == rd_addr_c) mem_rd = rd_dat_c;
  end
  assign sram_bus = (mem_oe && sramWr) ? mem_rd : 8'hzz;

  int          wr_cnt = 0, low_cyc = 0, addr_err = 0, overlap = 0, addr_glitch = 0;
  logic [18:0] wr_addr_log = '0, cur_addr = '0;
  logic [7:0]  wr_data_log = '0, drv_val = '0;
  logic        addr_chk = 1'b0;

  always @(posedge sramWr) begin
    if (reset) begin
      wr_cnt      <= wr_cnt + 1;
      wr_addr_log <= sramAddr;
      wr_data_log <= sram_bus;
    end
  end

  always @(negedge clock) begin
    if (!sramWr) begin
      low_cyc <= low_cyc + 1;
      drv_val <= sram_bus;
    end
    if (addr_chk && busy && sramAddr != cur_addr) addr_err <= addr_err + 1;
    if ((int'(vidAck) + int'(cpuAck) + int'(dmaAck)) > 1) overlap <= overlap + 1;
  end

  always @(sramAddr) begin
    if (reset && !sramWr) addr_glitch <= addr_glitch + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_released(input string name);
    checks++;
    if (!(sram_bus === 8'hzz || sram_bus === 8'h00)) begin
      errors++;
      $display("FAIL %s: bus 0x%0h expected released", name, sram_bus);
    end
  endtask

  task automatic set_req(input int port, input logic on, input logic wr,
                         input logic [18:0] a, input logic [7:0] d);
    case (port)
      0: begin vidReq = on; vidAddr = a; end
      1: begin cpuReq = on; cpuWr = wr; cpuAddr = a; cpuDi = d; end
      default: begin dmaReq = on; dmaWr = wr; dmaAddr = a; dmaDi = d; end
    endcase
  endtask

  function automatic int port_data(input int port);
    case (port)
      0:       return int'(vidData);
      1:       return int'(cpuDo);
      default: return int'(dmaDo);
    endcase
  endfunction

  typedef struct {
    int          port;
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int lat, low0, err0, wcnt0;
    logic [2:0] acks;
    mem_oe    = !v.wr;
    rd_addr_a = v.addr; rd_dat_a = v.data;
    rd_addr_b = v.addr; rd_dat_b = v.data;
    rd_addr_c = v.addr; rd_dat_c = v.data;
    @(negedge clock);
    low0 = low_cyc; err0 = addr_err; wcnt0 = wr_cnt;
    cur_addr = v.addr; addr_chk = 1'b1;
    set_req(v.port, 1'b1, v.wr, v.addr, v.data);
    lat = 0; acks = '0;
    while (acks == 3'b000 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      acks = {dmaAck, cpuAck, vidAck};
    end
    set_req(v.port, 1'b0, 1'b0, v.addr, v.data);
    chk("ack_port", int'(acks), 1 << v.port);
    chk("ack_latency", lat, v.exp_lat);
    chk("wr_low_cycles", low_cyc - low0, v.wr ? TB_WR_PULSE : 0);
    chk("addr_stable", addr_err - err0, 0);
    if (v.wr) begin
      chk("wr_count", wr_cnt - wcnt0, 1);
      chk("wr_addr", int'(wr_addr_log), int'(v.addr));
      chk("wr_data", int'(wr_data_log), int'(v.data));
      chk("bus_drive", int'(drv_val), int'(v.data));
    end else begin
      chk("rd_data", port_data(v.port), int'(v.data));
    end
    @(negedge clock);
    addr_chk = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int vid_cyc, cpu_cyc, dma_cyc, n_before, max_w, cyc;

    vecs[0] = '{1, 1'b0, 19'h12345, 8'hA5, 3};
    vecs[1] = '{1, 1'b1, 19'h00400, 8'h3C, 4};
    vecs[2] = '{0, 1'b0, 19'h7FFFF, 8'h81, 3};
    vecs[3] = '{2, 1'b1, 19'h00000, 8'hFF, 4};
    vecs[4] = '{2, 1'b0, 19'h55555, 8'h00, 3};
    vecs[5] = '{0, 1'b0, 19'h00001, 8'h7E, 3};
    vecs[6] = '{1, 1'b0, 19'h40000, 8'h01, 3};
    vecs[7] = '{2, 1'b1, 19'h7FFFF, 8'h96, 4};
    vecs[8] = '{1, 1'b1, 19'h2AAAA, 8'h5A, 4};

    // Power-on reset
    #2 reset = 1'b0;
    #1;
    chk("rst0_sramWr", int'(sramWr), 1);
    chk("rst0_sramAddr", int'(sramAddr), 0);
    chk("rst0_busy", int'(busy), 0);
    chk("rst0_acks", int'({dmaAck, cpuAck, vidAck}), 0);
    chk("rst0_data", int'({vidData, cpuDo, dmaDo}), 0);
    chk_released("rst0_bus");
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Simultaneous video and CPU reads
    mem_oe = 1'b1;
    rd_addr_a = 19'h00010; rd_dat_a = 8'h11;
    rd_addr_b = 19'h00020; rd_dat_b = 8'h22;
    rd_addr_c = 19'h00010; rd_dat_c = 8'h11;
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 19'h00010, 8'h00);
    set_req(1, 1'b1, 1'b0, 19'h00020, 8'h00);
    vid_cyc = 0; cpu_cyc = 0;
    for (int c = 1; c <= 15 && cpu_cyc == 0; c++) begin
      @(posedge clock); #1;
      if (vidAck) begin vid_cyc = c; vidReq = 1'b0; end
      if (cpuAck) begin cpu_cyc = c; cpuReq = 1'b0; end
    end
    vidReq = 1'b0; cpuReq = 1'b0;
    chk("sim_vid_ack_cycle", vid_cyc, 3);
    chk("sim_cpu_ack_cycle", cpu_cyc, 6);
    chk("sim_vid_data", int'(vidData), 8'h11);
    chk("sim_cpu_data", int'(cpuDo), 8'h22);
    @(negedge clock); @(negedge clock);

    // DMA starvation: video and CPU keep re-requesting
    rd_addr_a = 19'h00100; rd_dat_a = 8'h31;
    rd_addr_b = 19'h00200; rd_dat_b = 8'h32;
    rd_addr_c = 19'h00300; rd_dat_c = 8'h33;
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 19'h00100, 8'h00);
    set_req(1, 1'b1, 1'b0, 19'h00200, 8'h00);
    set_req(2, 1'b1, 1'b0, 19'h00300, 8'h00);
    dma_cyc = 0; n_before = 0; max_w = 0;
    for (int c = 1; c <= 60 && dma_cyc == 0; c++) begin
      @(posedge clock); #1;
      if (int'(dut.u_prio.dma_wait_q) > max_w) max_w = int'(dut.u_prio.dma_wait_q);
      if (dmaAck) begin dma_cyc = c; dmaReq = 1'b0; end
      else if (vidAck || cpuAck) n_before++;
    end
    vidReq = 1'b0; cpuReq = 1'b0; dmaReq = 1'b0;
    chk("starve_dma_ack_cycle", dma_cyc, 30);
    chk("starve_acks_before_dma", n_before, 9);
    chk("starve_max_wait", max_w, 8);
    chk("starve_dma_data", int'(dmaDo), 8'h33);
    chk("starve_wait_cleared", int'(dut.u_prio.dma_wait_q), 0);
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clock); cyc++; end
    chk("starve_drain", int'(busy), 0);
    @(negedge clock); @(negedge clock);

    // Reset asserted in the middle of a CPU read
    mem_oe = 1'b0;
    set_req(1, 1'b1, 1'b0, 19'h0ABCD, 8'h00);
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("rst1_sramWr", int'(sramWr), 1);
    chk("rst1_sramAddr", int'(sramAddr), 0);
    chk("rst1_busy", int'(busy), 0);
    chk("rst1_acks", int'({dmaAck, cpuAck, vidAck}), 0);
    chk("rst1_data", int'({vidData, cpuDo, dmaDo}), 0);
    chk_released("rst1_bus");
    cpuReq = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    n_before = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (vidAck || cpuAck || dmaAck) n_before++;
    end
    chk("rst1_no_ack", n_before, 0);

    // Reset while the write strobe is low
    cyc = wr_cnt;
    set_req(1, 1'b1, 1'b1, 19'h00123, 8'hC3);
    for (int c = 0; c < 10 && sramWr; c++) @(negedge clock);
    chk("rst2_reached_write", int'(sramWr), 0);
    #2 reset = 1'b0;
    #1;
    chk("rst2_sramWr", int'(sramWr), 1);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_cpuAck", int'(cpuAck), 0);
    chk_released("rst2_bus");
    cpuReq = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    n_before = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (cpuAck) n_before++;
    end
    chk("rst2_no_ack", n_before, 0);
    chk("rst2_no_write_logged", wr_cnt - cyc, 0);
    run_vec('{1, 1'b0, 19'h00123, 8'h6D, 3});
    run_vec('{1, 1'b1, 19'h00124, 8'h4B, 4});

    chk("ack_overlap", overlap, 0);
    chk("addr_change_while_wr_low", addr_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
